// File: rtl/dbus_shadow_pkg.sv
// Shared types and helpers for the dBus shadow responder.
// Entries are sized for the widest bus; narrower instances use the low lanes.
package dbus_shadow_pkg;

  localparam int SH_XLEN  = 64;
  localparam int SH_BYTES = SH_XLEN / 8;

  typedef struct packed {
    logic                hit;
    logic [SH_XLEN-1:0]  snap;
    logic [SH_BYTES-1:0] known;
  } shadow_entry_t;

  // Unsaturated byte-lane mask; the caller truncates to its bus width.
  function automatic logic [15:0] lane_mask(input logic [1:0] size, input logic [2:0] addr_lsbs);
    logic [15:0] m;
    m = (16'd1 << (4'd1 << size)) - 16'd1;
    return m << addr_lsbs;
  endfunction

  function automatic logic [63:0] word_idx(input logic [63:0] addr, input int unsigned lsb_w);
    return addr >> lsb_w;
  endfunction

endpackage

// File: rtl/dbus_shadow_fifo.sv
// In-order queue of read snapshots awaiting a response.
// Caller guarantees no push when full and no pop when empty.
module dbus_shadow_fifo
  import dbus_shadow_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  shadow_entry_t din,
  output shadow_entry_t head,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  shadow_entry_t mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/dbus_shadow_mem.sv
// dBus responder that pins read data of tracked words to a byte-accurate
// shadow captured at read acceptance; timing and untracked data stay free.
module dbus_shadow_mem
  import dbus_shadow_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NTRACK = 2,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_wr,
  input  logic [XLEN-1:0]              cmd_address,
  input  logic [XLEN-1:0]              cmd_data,
  input  logic [1:0]                   cmd_size,
  input  logic                         cmd_ready_rand,
  input  logic                         rsp_go,
  input  logic [XLEN-1:0]              rsp_data_rand,
  output logic                         rsp_ready,
  output logic [XLEN-1:0]              rsp_data,
  input  logic [NTRACK*XLEN-1:0]       track_addr,
  output logic [$clog2(DEPTH+1)-1:0]   pending,
  output logic                         misalign_err
);

  localparam int NB    = XLEN / 8;
  localparam int LSB_W = $clog2(NB);
  localparam int CW    = $clog2(DEPTH + 1);

  logic [NTRACK-1:0][XLEN-1:0] shadow;
  logic [NTRACK-1:0][NB-1:0]   known;
  logic [NTRACK-1:0]           match;
  logic [NB-1:0]               lmask;
  logic                        wide, misal, full, wr_acc, rd_acc;
  shadow_entry_t               push_entry, head;

  always_comb begin
    for (int i = 0; i < NTRACK; i++)
      match[i] = word_idx(64'(cmd_address), LSB_W) ==
                 word_idx(64'(track_addr[i*XLEN +: XLEN]), LSB_W);
  end

  // Access sizes at or beyond the bus width cover every lane.
  assign wide  = (5'd1 << cmd_size) >= 5'(NB);
  assign lmask = wide ? '1 : NB'(lane_mask(cmd_size, 3'(cmd_address[LSB_W-1:0])));
  assign misal = |(cmd_address[2:0] & ((3'd1 << cmd_size) - 3'd1));

  assign full      = pending == CW'(DEPTH);
  assign cmd_ready = cmd_ready_rand && (cmd_wr || !full);
  assign wr_acc    = cmd_valid && cmd_ready && cmd_wr;
  assign rd_acc    = cmd_valid && cmd_ready && !cmd_wr;
  assign rsp_ready = rsp_go && (pending != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      known <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < NTRACK; i++)
        for (int b = 0; b < NB; b++)
          if (match[i] && lmask[b]) begin
            shadow[i][b*8 +: 8] <= cmd_data[b*8 +: 8];
            known[i][b]         <= 1'b1;
          end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                           misalign_err <= 1'b0;
    else if (cmd_valid && cmd_ready && misal) misalign_err <= 1'b1;
  end

  // Descending scan so the lowest matching slot supplies the snapshot.
  always_comb begin
    push_entry = '0;
    for (int i = NTRACK - 1; i >= 0; i--)
      if (match[i]) begin
        push_entry.hit   = 1'b1;
        push_entry.snap  = SH_XLEN'(shadow[i]);
        push_entry.known = SH_BYTES'(known[i]);
      end
  end

  dbus_shadow_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rd_acc),
    .pop   (rsp_ready),
    .din   (push_entry),
    .head  (head),
    .count (pending)
  );

  always_comb begin
    rsp_data = rsp_data_rand;
    if (rsp_ready && head.hit)
      for (int b = 0; b < NB; b++)
        if (head.known[b]) rsp_data[b*8 +: 8] = head.snap[b*8 +: 8];
  end

  if (XLEN < SH_XLEN) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^{head.snap[SH_XLEN-1:XLEN], head.known[SH_BYTES-1:NB]};
  end

endmodule

// File: tb/tb_dbus_shadow_mem.sv
// Directed bench: stimulus pushes expected read responses, a monitor pops and compares.
module tb_dbus_shadow_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_wr;
  logic [31:0] cmd_address, cmd_data;
  logic [1:0]  cmd_size;
  logic        cmd_ready_rand, rsp_go, rsp_ready;
  logic [31:0] rsp_data_rand, rsp_data;
  logic [63:0] track_addr;
  logic [2:0]  pending;
  logic        misalign_err;

  typedef struct {
    logic [31:0] val;
    logic [3:0]  m;
  } exp_t;

  exp_t q[$];
  int   npass = 0;
  int   ntotal = 0;

  always #5 clk = ~clk;

  dbus_shadow_mem #(.XLEN(32), .NTRACK(2), .DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_wr         (cmd_wr),
    .cmd_address    (cmd_address),
    .cmd_data       (cmd_data),
    .cmd_size       (cmd_size),
    .cmd_ready_rand (cmd_ready_rand),
    .rsp_go         (rsp_go),
    .rsp_data_rand  (rsp_data_rand),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .track_addr     (track_addr),
    .pending        (pending),
    .misalign_err   (misalign_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s got=%h want=%h", nm, act, exp);
  endtask

  // Known bytes come from the hand-computed value, the rest from the free input.
  always @(negedge clk) begin
    if (rsp_ready === 1'b1) begin
      ntotal++;
      if (q.size() == 0) begin
        $display("FAIL rsp_unexpected got=%h want=no response", rsp_data);
      end else begin
        exp_t        e;
        logic [31:0] w;
        e = q.pop_front();
        for (int b = 0; b < 4; b++)
          w[b*8 +: 8] = e.m[b] ? e.val[b*8 +: 8] : rsp_data_rand[b*8 +: 8];
        if (rsp_data === w) npass++;
        else $display("FAIL rsp_data got=%h want=%h", rsp_data, w);
      end
    end
  end

  task automatic cmd(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    cmd_valid = 1'b1; cmd_wr = wr; cmd_address = a; cmd_data = d; cmd_size = sz;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] v, input logic [3:0] m);
    exp_t e;
    e.val = v; e.m = m;
    q.push_back(e);
    cmd(1'b0, a, 32'h0, 2'd2);
  endtask

  task automatic drain(input string nm);
    rsp_go = 1'b1;
    for (int i = 0; i < 20 && pending != 3'd0; i++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk(nm, 32'(pending), 32'd0);
    @(posedge clk); #1;
    rsp_go = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_address = '0; cmd_data = '0;
    cmd_size = 2'd0; cmd_ready_rand = 1'b1; rsp_go = 1'b0; rsp_data_rand = 32'h0;
    track_addr = {32'h0000_0200, 32'h0000_0100};
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_rsp_ready", 32'(rsp_ready), 32'd0);
    chk("rst_misalign", 32'(misalign_err), 32'd0);
    chk("cmd_ready_follow1", 32'(cmd_ready), 32'd1);
    cmd_ready_rand = 1'b0;
    #1 chk("cmd_ready_follow0", 32'(cmd_ready), 32'd0);
    cmd_ready_rand = 1'b1;
    @(posedge clk); #1;

    // Full word store then load with one-cycle minimum latency.
    rsp_data_rand = 32'h5555_5555;
    cmd(1'b1, 32'h100, 32'hDEAD_BEEF, 2'd2);
    rsp_go = 1'b1;
    begin
      exp_t e;
      e.val = 32'hDEAD_BEEF; e.m = 4'hF;
      q.push_back(e);
    end
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_address = 32'h100; cmd_size = 2'd2;
    @(negedge clk);
    chk("lat_same_cycle", 32'(rsp_ready), 32'd0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("lat_next_cycle", 32'(rsp_ready), 32'd1);
    @(posedge clk); #1;
    rsp_go = 1'b0;

    // Single known byte merged with free data.
    rsp_data_rand = 32'h1122_3344;
    cmd(1'b1, 32'h202, 32'h00AA_0000, 2'd0);
    load(32'h200, 32'h00AA_0000, 4'b0100);
    drain("drain_byte");

    // Snapshot ordering, then push+pop in one cycle.
    cmd(1'b1, 32'h100, 32'h0000_0001, 2'd2);
    load(32'h100, 32'h0000_0001, 4'hF);
    cmd(1'b1, 32'h100, 32'h0000_0002, 2'd2);
    load(32'h100, 32'h0000_0002, 4'hF);
    @(negedge clk);
    chk("pending_two", 32'(pending), 32'd2);
    @(posedge clk); #1;
    rsp_go = 1'b1;
    load(32'h100, 32'h0000_0002, 4'hF);
    @(negedge clk);
    chk("push_pop_pending", 32'(pending), 32'd2);
    @(posedge clk); #1;
    drain("drain_snap");

    // Full queue: loads stall, stores still pass, same-cycle pop frees nothing.
    rsp_data_rand = 32'hCAFE_F00D;
    for (int i = 0; i < 4; i++) load(32'h300, 32'h0, 4'h0);
    @(negedge clk);
    chk("full_pending", 32'(pending), 32'd4);
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_address = 32'h300; cmd_size = 2'd2;
    #1 chk("full_load_stall", 32'(cmd_ready), 32'd0);
    cmd_wr = 1'b1; cmd_address = 32'h104; cmd_data = 32'h1234_5678;
    #1 chk("full_store_ok", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("full_after_store", 32'(pending), 32'd4);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_address = 32'h300; rsp_go = 1'b1;
    @(negedge clk);
    chk("full_pop_no_free", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("full_pop_pending", 32'(pending), 32'd3);
    @(posedge clk); #1;
    drain("drain_full");

    // Misaligned halfword still updates the shadow; flag is sticky.
    rsp_data_rand = 32'h7777_7777;
    cmd(1'b1, 32'h101, 32'h00BB_CC00, 2'd1);
    @(negedge clk);
    chk("misalign_set", 32'(misalign_err), 32'd1);
    @(posedge clk); #1;
    cmd(1'b1, 32'h300, 32'h0, 2'd2);
    @(negedge clk);
    chk("misalign_sticky", 32'(misalign_err), 32'd1);
    @(posedge clk); #1;
    load(32'h100, 32'h00BB_CC02, 4'hF);
    drain("drain_misal");

    // Reset with outstanding reads drops them and forgets the shadows.
    for (int i = 0; i < 3; i++) load(32'h300, 32'h0, 4'h0);
    @(negedge clk);
    chk("pre_rst_pending", 32'(pending), 32'd3);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    q.delete();
    rsp_go = 1'b1;
    @(negedge clk);
    chk("mid_rst_pending", 32'(pending), 32'd0);
    chk("mid_rst_rsp_ready", 32'(rsp_ready), 32'd0);
    chk("mid_rst_misalign", 32'(misalign_err), 32'd0);
    @(posedge clk); #1;
    rsp_data_rand = 32'h9ABC_DEF0;
    load(32'h100, 32'h0, 4'h0);
    drain("drain_rst");

    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
